fetch_unit: RTL

- Instruction fetch front end: produces the 32-bit `Instr` word consumed by `controller`, and consumes that block's branch/jump outcome (PCSrc plus target) as a redirect.
- Issues in-order, pipelined word requests to instruction memory and buffers returned words with their PCs.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Discards wrong-path responses after a redirect.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states, buffered
// entry layout and the word-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_enum;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries. Flush wins over push; a
// push and a pop in the same cycle are allowed even when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           push,
    input  fetch_entry_t   push_data,
    input  logic           pop,
    input  logic           flush,
    output fetch_entry_t   head,
    output logic           empty,
    output logic [CW-1:0]  count
);

    fetch_entry_t mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

    assert property (@(posedge clk) disable iff (!reset_n)
        !(do_push && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited pipelined imem requests, an
// in-order response buffer, and redirect handling that drops wrong-path words.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_enum state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_push_data;
    logic            req_fire;
    logic [CW:0]     credits_used;
    logic [31:0]     redirect_pc;

    // In-flight requests plus buffered words may never exceed the buffer size.
    assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = (state_q != IDLE) && (credits_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign redirect_pc    = align_word(redirect_target);

    assign instr_valid    = !fifo_empty;
    assign Instr          = fifo_empty ? '0 : fifo_head.instr;
    assign instr_pc       = fifo_empty ? '0 : fifo_head.pc;
    assign fifo_pop       = instr_valid && instr_ready;
    assign fifo_push_data = '{pc: resp_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        discard_d     = discard_q;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            fifo_flush = 1'b1;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
            if (imem_rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + 32'(INSTR_BYTES);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = (redirect_valid && (outstanding_d != '0)) ? DRAIN : FETCH;
            DRAIN:   state_d = (discard_d == '0) ? FETCH : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> (outstanding_q != '0));
    assert property (@(posedge clk) disable iff (!reset_n)
        (outstanding_q <= CW'(FIFO_DEPTH)) && (discard_q <= outstanding_q));

endmodule
